mul_ex_stage: RTL and testbench

- Iterative radix-2 shift-add multiply unit in the multi-cycle EX path. It is the producer of the WB stage's ex_valid / ex_wr_reg / ex_result inputs.
- Accepts one MUL from issue and computes the low DATA_WIDTH bits of the product over several cycles.
- Holds the result until the WB port is free. WB always gives priority to a valid MEM-stage instruction, so the result may wait.

---
 rtl/mul_ex_stage.sv | 131 +++++++++++++
 tb/tb_mul_ex_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mul_ex_stage.sv
// mul_ex_stage: iterative radix-2 shift-add multiplier for the multi-cycle EX path.
// Produces the low DATA_WIDTH bits of a*b, one multiplier bit per cycle, and
// holds the result for the WB stage until the WB port is free (MEM has priority).
// Optional build macro: MUL_EARLY_OUT_EN -- finish as soon as the remaining
// multiplier bits are all zero instead of always iterating DATA_WIDTH times.
module mul_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [DATA_WIDTH-1:0]     a_i,
    input  logic [DATA_WIDTH-1:0]     b_i,
    input  logic [REGISTER_WIDTH-1:0] wr_reg_i,
    input  logic                      flush_i,
    input  logic                      wb_mem_valid_i,
    output logic                      busy_o,
    output logic                      ex_valid_o,
    output logic [REGISTER_WIDTH-1:0] ex_wr_reg_o,
    output logic [DATA_WIDTH-1:0]     ex_result_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_reg, state_next;
    logic [DATA_WIDTH-1:0]     acc_reg, acc_next;
    logic [DATA_WIDTH-1:0]     mcand_reg, mcand_next;
    logic [DATA_WIDTH-1:0]     mplier_reg, mplier_next;
    logic [CNT_W-1:0]          cnt_reg, cnt_next;
    logic [REGISTER_WIDTH-1:0] dst_reg, dst_next;

    logic consume;
    logic load;
    logic last_iter;

    // A result leaves DONE only when MEM does not own the WB port this cycle.
    assign consume = (state_reg == ST_DONE) && !wb_mem_valid_i;

    // New operands are accepted from IDLE or in the consume cycle (back-to-back);
    // a start that coincides with a flush is dropped.
    assign load = start_i && !flush_i && ((state_reg == ST_IDLE) || consume);

`ifdef MUL_EARLY_OUT_EN
    // Stop once no set multiplier bits remain after this iteration's shift.
    assign last_iter = (cnt_reg == LAST_CNT) || (mplier_reg[DATA_WIDTH-1:1] == '0);
`else
    assign last_iter = (cnt_reg == LAST_CNT);
`endif

    // State and datapath registers; async reset clears everything.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= ST_IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            dst_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
            dst_reg    <= dst_next;
        end
    end

    // Next-state and shift-add iteration; flush overrides every transition.
    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        cnt_next    = cnt_reg;
        dst_next    = dst_reg;

        case (state_reg)
            ST_IDLE: begin
                // load handled below
            end
            ST_BUSY: begin
                if (mplier_reg[0]) begin
                    acc_next = acc_reg + mcand_reg;
                end
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + 1'b1;
                if (last_iter) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (consume) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (load) begin
            mcand_next  = a_i;
            mplier_next = b_i;
            dst_next    = wr_reg_i;
            acc_next    = '0;
            cnt_next    = '0;
            state_next  = ST_BUSY;
        end

        // acc is intentionally left alone; the result is meaningless while invalid.
        if (flush_i) begin
            state_next = ST_IDLE;
        end
    end

    assign ex_valid_o  = (state_reg == ST_DONE);
    assign ex_result_o = acc_reg;
    assign ex_wr_reg_o = dst_reg;
    assign busy_o      = (state_reg == ST_BUSY) || ((state_reg == ST_DONE) && wb_mem_valid_i);

endmodule

// File: tb/tb_mul_ex_stage.sv
// tb_mul_ex_stage: directed-vector bench for mul_ex_stage with hand-computed
// products, WB contention, back-to-back issue, flush and async reset cases.
module tb_mul_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wr_reg;
    logic        flush;
    logic        wb_mem_valid;
    logic        busy;
    logic        ex_valid;
    logic [4:0]  ex_wr_reg;
    logic [31:0] ex_result;

    int n_checks = 0;
    int n_fail   = 0;

    mul_ex_stage #(.DATA_WIDTH(32), .REGISTER_WIDTH(5)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .a_i            (a),
        .b_i            (b),
        .wr_reg_i       (wr_reg),
        .flush_i        (flush),
        .wb_mem_valid_i (wb_mem_valid),
        .busy_o         (busy),
        .ex_valid_o     (ex_valid),
        .ex_wr_reg_o    (ex_wr_reg),
        .ex_result_o    (ex_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Expected number of BUSY cycles for multiplier b.
    function automatic int exp_cycles(input logic [31:0] bv);
`ifdef MUL_EARLY_OUT_EN
        int m = 1;
        for (int i = 0; i < 32; i++) if (bv[i]) m = i + 1;
        return m;
`else
        return 32;
`endif
    endfunction

    // Drive a start pulse; returns sampled #1 after the accepting edge.
    task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic [4:0] r);
        @(negedge clk);
        start = 1'b1; a = av; b = bv; wr_reg = r;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // From the first BUSY sample, count cycles until ex_valid rises and check the result.
    task automatic wait_result(input string tag, input int ncyc, input logic [31:0] res,
                               input logic [4:0] r);
        int  n = 0;
        bit  busy_bad = 1'b0;
        while (!ex_valid && n < 200) begin
            if (!busy) busy_bad = 1'b1;
            n++;
            @(posedge clk); #1;
        end
        check({tag, "_cycles"}, 64'(n), 64'(ncyc));
        check({tag, "_busy_held"}, 64'(busy_bad), 64'd0);
        check({tag, "_valid"}, 64'(ex_valid), 64'd1);
        check({tag, "_result"}, 64'(ex_result), 64'(res));
        check({tag, "_wr_reg"}, 64'(ex_wr_reg), 64'(r));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; wr_reg = '0;
        flush = 1'b0; wb_mem_valid = 1'b0;
        #1;
        check("rst_valid", 64'(ex_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", 64'(ex_result), 64'd0);
        check("rst_wr_reg", 64'(ex_wr_reg), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        // Basic multiply, then auto-consume with WB free.
        launch(32'd3, 32'd5, 5'd7);
        check("basic_busy_first", 64'(busy), 64'd1);
        wait_result("basic", exp_cycles(32'd5), 32'd15, 5'd7);
        check("basic_busy_in_done", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("basic_idle_valid", 64'(ex_valid), 64'd0);
        check("basic_idle_busy", 64'(busy), 64'd0);

        // Wrap-around products.
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        wait_result("wrap_ones", exp_cycles(32'hFFFF_FFFF), 32'h0000_0001, 5'd3);
        @(posedge clk); #1;
        launch(32'h8000_0000, 32'd2, 5'd9);
        wait_result("wrap_msb", exp_cycles(32'd2), 32'h0000_0000, 5'd9);
        @(posedge clk); #1;
        launch(32'h1234_5678, 32'h10, 5'd17);
        wait_result("shift16", exp_cycles(32'h10), 32'h2345_6780, 5'd17);
        @(posedge clk); #1;
        launch(32'hDEAD_BEEF, 32'd0, 5'd4);
        wait_result("b_zero", exp_cycles(32'd0), 32'd0, 5'd4);
        @(posedge clk); #1;
        launch(32'd1, 32'h8000_0000, 5'd31);
        wait_result("b_msb", exp_cycles(32'h8000_0000), 32'h8000_0000, 5'd31);

        // WB contention: hold MEM priority for 4 cycles while in DONE.
        @(negedge clk); wb_mem_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d_valid", i), 64'(ex_valid), 64'd1);
            check($sformatf("hold%0d_busy", i), 64'(busy), 64'd1);
            check($sformatf("hold%0d_result", i), 64'(ex_result), 64'h8000_0000);
            check($sformatf("hold%0d_wr_reg", i), 64'(ex_wr_reg), 64'd31);
        end
        @(negedge clk); wb_mem_valid = 1'b0;
        #1 check("consume_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("after_consume_valid", 64'(ex_valid), 64'd0);

        // Back-to-back: new start in the consume cycle.
        launch(32'd10, 32'd11, 5'd2);
        wait_result("b2b_first", exp_cycles(32'd11), 32'd110, 5'd2);
        launch(32'd6, 32'd7, 5'd12);
        check("b2b_busy_immediate", 64'(busy), 64'd1);
        check("b2b_valid_dropped", 64'(ex_valid), 64'd0);
        wait_result("b2b_second", exp_cycles(32'd7), 32'd42, 5'd12);
        @(posedge clk); #1;

        // Flush at BUSY cycle 10.
        launch(32'd3, 32'h8000_0005, 5'd5);
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_valid", 64'(ex_valid), 64'd0);
        begin
            bit rose = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (ex_valid) rose = 1'b1;
            end
            check("flush_never_valid", 64'(rose), 64'd0);
        end

        // Flush together with start in IDLE: start is dropped.
        @(negedge clk); start = 1'b1; flush = 1'b1; a = 32'd2; b = 32'd2; wr_reg = 5'd1;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 64'(busy), 64'd0);
        check("flush_start_valid", 64'(ex_valid), 64'd0);
        repeat (3) @(posedge clk); #1;
        check("flush_start_still_idle", 64'(busy), 64'd0);

        // Async reset mid-BUSY, no clock edge in between.
        launch(32'd3, 32'h8000_0005, 5'd7);
        repeat (5) @(posedge clk);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_valid", 64'(ex_valid), 64'd0);
        check("arst_result", 64'(ex_result), 64'd0);
        check("arst_wr_reg", 64'(ex_wr_reg), 64'd0);
        @(negedge clk); rst = 1'b0;
        repeat (40) @(posedge clk); #1;
        check("arst_no_result", 64'(ex_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
